// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: store sizes, load modes,
// the FSM state set and the decoded access width.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_WORD    = 2'b00,
    ST_HALF    = 2'b01,
    ST_BYTE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } st_size_e;

  typedef enum logic [2:0] {
    LD_WORD   = 3'b000,
    LD_HALF_S = 3'b001,
    LD_HALF_U = 3'b010,
    LD_BYTE_S = 3'b011,
    LD_BYTE_U = 3'b100
  } ld_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE,
    SZ_BAD
  } acc_size_e;

  // Stores take their width from st_size, loads from ld_mode (unknown modes read a word).
  function automatic acc_size_e access_size(input logic       we,
                                            input logic [1:0] st_size,
                                            input logic [2:0] ld_mode);
    acc_size_e sz;
    sz = SZ_WORD;
    if (we) begin
      case (st_size)
        ST_WORD: sz = SZ_WORD;
        ST_HALF: sz = SZ_HALF;
        ST_BYTE: sz = SZ_BYTE;
        default: sz = SZ_BAD;
      endcase
    end else begin
      case (ld_mode)
        LD_HALF_S, LD_HALF_U: sz = SZ_HALF;
        LD_BYTE_S, LD_BYTE_U: sz = SZ_BYTE;
        default:              sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for requests (fault check, byte enables, replicated
// store data) and lane extraction / extension for load responses.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        req_we,
  input  logic [1:0]  req_st_size,
  input  logic [2:0]  req_ld_mode,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic        req_fault,
  output logic [3:0]  req_be,
  output logic [31:0] req_lanes,
  input  logic [2:0]  rsp_ld_mode,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rsp_ext
);

  acc_size_e   size;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    size      = access_size(req_we, req_st_size, req_ld_mode);
    req_fault = 1'b0;
    req_be    = 4'b1111;
    req_lanes = '0;
    case (size)
      SZ_WORD: req_fault = (req_addr_lo != 2'b00);
      SZ_HALF: req_fault = req_addr_lo[0];
      SZ_BYTE: req_fault = 1'b0;
      default: req_fault = 1'b1;
    endcase
    if (req_we) begin
      case (size)
        SZ_HALF: begin
          req_be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
          req_lanes = {2{req_wdata[15:0]}};
        end
        SZ_BYTE: begin
          req_be    = 4'b0001 << req_addr_lo;
          req_lanes = {4{req_wdata[7:0]}};
        end
        default: req_lanes = req_wdata;
      endcase
    end
  end

  always_comb begin
    half_v  = rsp_addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
    byte_v  = rsp_rdata[{rsp_addr_lo, 3'b000} +: 8];
    rsp_ext = rsp_rdata;
    case (rsp_ld_mode)
      LD_HALF_S: rsp_ext = {{16{half_v[15]}}, half_v};
      LD_HALF_U: rsp_ext = {16'h0000, half_v};
      LD_BYTE_S: rsp_ext = {{24{byte_v[7]}}, byte_v};
      LD_BYTE_U: rsp_ext = {24'h000000, byte_v};
      default:   rsp_ext = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM load-store unit: accepts one op at a time, drives a registered
// variable-latency memory port with timeout, and reports completion or fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic [1:0]        ex_st_size,
  input  logic [2:0]        ex_ld_mode,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       wb_rdata,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  // Counter value at the end of the last allowed request cycle (2^TMO_W-1 cycles in REQ).
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lat_mode;
  logic [1:0]       lat_lo;
  logic             accept, reject, ack_hit, timeout;
  logic             req_fault;
  logic [3:0]       req_be;
  logic [31:0]      req_lanes, rsp_ext;

  mem_lane_align u_align (
    .req_we      (ex_we),
    .req_st_size (ex_st_size),
    .req_ld_mode (ex_ld_mode),
    .req_addr_lo (ex_addr[1:0]),
    .req_wdata   (ex_wdata),
    .req_fault   (req_fault),
    .req_be      (req_be),
    .req_lanes   (req_lanes),
    .rsp_ld_mode (lat_mode),
    .rsp_addr_lo (lat_lo),
    .rsp_rdata   (mem_rdata),
    .rsp_ext     (rsp_ext)
  );

  assign stall = ex_valid && !(state_q == S_RESP || state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    ack_hit = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          cnt_d = '0;
          if (req_fault) begin
            reject  = 1'b1;
            state_d = S_ERR;
          end else begin
            accept  = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack arriving on the final timeout cycle still completes the access.
        if (mem_ack) begin
          ack_hit = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lat_mode  <= '0;
      lat_lo    <= '0;
      wb_valid  <= 1'b0;
      wb_rdata  <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= ack_hit;
      misalign <= reject;
      bus_err  <= timeout;
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= ex_we;
        mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= req_be;
        mem_wdata <= req_lanes;
        lat_mode  <= ex_ld_mode;
        lat_lo    <= ex_addr[1:0];
      end else if (ack_hit || timeout) begin
        mem_req <= 1'b0;
      end
      if (ack_hit && !mem_we) wb_rdata <= rsp_ext;
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter TMO_W, default 8: timeout counter width; timeout = 2^TMO_W-1 cycles.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ex_valid  in  1  memory op present in EX/MEM.
REQ-006 SHALL have port ex_we  in  1  1=store, 0=load.
REQ-007 SHALL have port ex_st_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
REQ-008 SHALL have port ex_ld_mode  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others = word.
REQ-009 SHALL have port ex_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port ex_wdata  in  32  store data, right-justified.
REQ-011 SHALL have port stall  out  1  hold pipeline.
REQ-012 SHALL have port wb_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port wb_rdata  out  32  extended load data.
REQ-014 SHALL have port misalign  out  1  one-cycle alignment/illegal-size fault pulse.
REQ-015 SHALL have port bus_err  out  1  one-cycle timeout pulse.
REQ-016 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W (bits[1:0]=0), mem_be out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32: variable-latency memory port.

Function
REQ-017 SHALL implement FSM IDLE, REQ, RESP, ERR; all mem_* outputs registered.
REQ-018 IDLE: ex_valid with aligned legal op SHALL latch request, go REQ; misaligned/illegal SHALL go ERR without mem_req.
REQ-019 Alignment: word needs addr[1:0]=00, half addr[0]=0, byte any; size from ex_st_size (store) or ex_ld_mode (load).
REQ-020 REQ: mem_req=1, fields stable until mem_ack; mem_ack -> RESP, capture mem_rdata.
REQ-021 REQ: counter increments per cycle; reaching 2^TMO_W-1 without ack -> ERR with bus_err; ack in same cycle wins.
REQ-022 RESP: wb_valid=1 one cycle (loads and stores), -> IDLE.
REQ-023 ERR: misalign or bus_err=1 one cycle, wb_valid=0, -> IDLE.
REQ-024 stall SHALL equal ex_valid AND state not in {RESP, ERR}.
REQ-025 Latency: accept cycle 0, mem_req from cycle 1, ack cycle k, wb_valid cycle k+1; minimum 3 cycles per op.
REQ-026 Stores: byte be=1<<addr[1:0], byte replicated in 4 lanes; half be=0011/1100 by addr[1], half replicated; word be=1111.
REQ-027 Loads: mem_be=1111, mem_wdata=0; lane selected by latched addr[1:0], little-endian, extended per ld_mode.
REQ-028 mem_ack outside REQ SHALL be ignored.
REQ-029 wb_rdata SHALL hold last load value until next load completes; stores leave it unchanged.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, counter 0, and mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rdata, misalign, bus_err to 0, including mid-transaction.
REQ-031 First accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-032 Package mem_pkg SHALL hold st_size and ld_mode encodings and the FSM state enum.
REQ-033 Combinational sub-module mem_lane_align SHALL perform be/wdata steering and load extraction/extension; FSM and counter in mem_access_unit.

Verification
REQ-034 Store byte 0xA5 at 0x103, ack 2 cycles after req -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100, wb_valid at cycle 4.
REQ-035 Load half signed at 0x202, mem_rdata=0x8001_1234 -> wb_rdata=0xFFFF8001; unsigned -> 0x00008001.
REQ-036 Load word at 0x301 -> misalign pulse cycle 1, no mem_req, stall low that cycle.
REQ-037 TMO_W=4, no ack -> bus_err 15 cycles after mem_req rises, then IDLE; ack on cycle 15 -> wb_valid, no bus_err.
REQ-038 rst_n low during REQ -> mem_req 0 same cycle; post-reset load completes normally.
